// File: rtl/awgn_pkg.sv
// Shared helpers for the AWGN datapath blocks.
//   clog2         : ceiling log2, usable in parameter and port declarations
//   lzc_width     : width of a leading-zero count that can also hold the value WIDTH
//   lzc_zero_code : count reported for an all-zero word (MSB of the count set, rest 0)
//   LZD_LEAF_W    : width of the leaf detector in the leading-zero tree
package awgn_pkg;

  localparam int LZD_LEAF_W = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int lzc_width(input int width);
    return clog2(width) + 1;
  endfunction

  // For a power-of-two width the value WIDTH is exactly the MSB of the count.
  function automatic int lzc_zero_code(input int width);
    return width;
  endfunction

endpackage

// File: rtl/lzc_norm_pipe_lzd.sv
// lzd_tree: combinational leading-zero detector for a power-of-two width W >= 2.
// Built recursively: 2-bit leaves, merged pairwise with v = vh|vl, p = {~vh, vh ? ph : pl}.
//   a : word to inspect
//   p : number of leading zeros, meaningful only when v = 1
//   v : at least one bit of a is set
module lzd_tree
  import awgn_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]        a,
  output logic [clog2(W)-1:0] p,
  output logic                v
);

  generate
    if (W == LZD_LEAF_W) begin : g_leaf
      assign v = a[1] | a[0];
      assign p = ~a[1];
    end else begin : g_node
      localparam int HW = W / 2;

      logic [clog2(HW)-1:0] ph;
      logic [clog2(HW)-1:0] pl;
      logic                 vh;
      logic                 vl;

      lzd_tree #(.W(HW)) u_hi (.a(a[W-1:HW]), .p(ph), .v(vh));
      lzd_tree #(.W(HW)) u_lo (.a(a[HW-1:0]), .p(pl), .v(vl));

      // A set bit in the upper half decides the count; otherwise the whole
      // upper half is leading zeros, which the new MSB of p accounts for.
      assign v = vh | vl;
      assign p = {~vh, vh ? ph : pl};
    end
  endgenerate

endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage pipelined leading-zero counter and normaliser.
// Stage 1 registers the word, tag, leading-zero count and zero flag; stage 2
// registers the left-shifted word so its MSB is 1 (all zeros for a zero word).
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data, in_tag       : word to normalise and its sideband tag
//   out_valid/out_ready   : output handshake
//   out_norm              : in_data << out_lzc
//   out_lzc               : leading zeros, 0..WIDTH (WIDTH for a zero word)
//   out_zero              : input word was zero
//   out_tag               : tag travelling with the result
module lzc_norm_pipe
  import awgn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int LZC_W = lzc_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_norm,
  output logic [LZC_W-1:0] out_lzc,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [LZC_W-1:0] ZERO_LZC = LZC_W'(lzc_zero_code(WIDTH));

  logic [LZC_W-2:0] tree_p;
  logic             tree_v;
  logic [LZC_W-1:0] in_lzc;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic [LZC_W-1:0] s1_lzc;
  logic             s1_zero;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic             s2_load;
  logic [WIDTH-1:0] norm_next;

  lzd_tree #(.W(WIDTH)) u_lzd (
    .a (in_data),
    .p (tree_p),
    .v (tree_v)
  );

  assign in_lzc = tree_v ? {1'b0, tree_p} : ZERO_LZC;

  // Each stage may advance when it is empty or the stage after it is moving,
  // so a full pipe still accepts and emits on the same edge.
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid & s1_adv;
  assign s2_load  = s1_valid & s2_adv;

  // NOTE: give every always_comb output a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    norm_next = s1_data << s1_lzc[LZC_W-2:0];
    if (s1_zero) norm_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload registers are reset too because the outputs have defined reset values; there is no memory here.
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (in_fire) begin
        s1_data <= in_data;
        s1_tag  <= in_tag;
        s1_lzc  <= in_lzc;
        s1_zero <= ~tree_v;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_norm  <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s2_load) begin
        out_norm <= norm_next;
        out_lzc  <= s1_lzc;
        out_zero <= s1_zero;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Self-checking bench for lzc_norm_pipe: directed vectors at WIDTH=32, a
// backpressure and a mid-flight reset scenario, a random scoreboard run, and a
// single-one sweep on WIDTH=8/16/64 instances.
module tb_lzc_norm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_norm;
  logic [5:0]  out_lzc;
  logic        out_zero;
  logic [3:0]  out_tag;

  logic        v8 = 1'b0, v16 = 1'b0, v64 = 1'b0;
  logic        r8, r16, r64;
  logic [7:0]  d8 = '0;
  logic [15:0] d16 = '0;
  logic [63:0] d64 = '0;
  logic        ov8, ov16, ov64;
  logic [7:0]  on8;
  logic [15:0] on16;
  logic [63:0] on64;
  logic [3:0]  ol8;
  logic [4:0]  ol16;
  logic [6:0]  ol64;
  logic        oz8, oz16, oz64;
  logic [3:0]  ot8, ot16, ot64;
  logic [3:0]  sweep_tag = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] norm;
    logic [5:0]  lzc;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  always #5 clk = ~clk;

  lzc_norm_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_norm(out_norm),
    .out_lzc(out_lzc), .out_zero(out_zero), .out_tag(out_tag)
  );

  lzc_norm_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(d8), .in_tag(sweep_tag),
    .out_valid(ov8), .out_ready(1'b1), .out_norm(on8), .out_lzc(ol8), .out_zero(oz8), .out_tag(ot8)
  );

  lzc_norm_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_data(d16), .in_tag(sweep_tag),
    .out_valid(ov16), .out_ready(1'b1), .out_norm(on16), .out_lzc(ol16), .out_zero(oz16), .out_tag(ot16)
  );

  lzc_norm_pipe #(.WIDTH(64), .TAG_W(4)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_data(d64), .in_tag(sweep_tag),
    .out_valid(ov64), .out_ready(1'b1), .out_norm(on64), .out_lzc(ol64), .out_zero(oz64), .out_tag(ot64)
  );

  // Reference model: scan from the MSB for the first one.
  function automatic res_t ref_model(input logic [31:0] d, input logic [3:0] t);
    res_t r;
    int   lz;
    lz = 32;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) begin
        lz = 31 - i;
        break;
      end
    end
    r.lzc  = 6'(lz);
    r.zero = (d == 32'd0);
    r.norm = (lz == 32) ? 32'd0 : (d << lz);
    r.tag  = t;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_norm !== 32'd0) begin n_fail++; $display("FAIL reset_out_norm got %h want 0", out_norm); end
    n_checks++; if (out_lzc !== 6'd0) begin n_fail++; $display("FAIL reset_out_lzc got %0d want 0", out_lzc); end
    n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero got %0b want 0", out_zero); end
    n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
    rst = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_out_valid got %0b want 0", out_valid); end
  endtask

  // Back-to-back words, out_ready high: each result appears two cycles after its input.
  task automatic test_back_to_back();
    logic [31:0] d   [3] = '{32'h8000_0000, 32'h0000_8000, 32'h0000_0001};
    logic [3:0]  t   [3] = '{4'd1, 4'd2, 4'd3};
    logic [5:0]  lzc [3] = '{6'd0, 6'd16, 6'd31};
    out_ready = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin
        in_data = d[c];
        in_tag  = t[c];
      end
      step();
      if (c == 0) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency out_valid got %0b want 0", out_valid); end
      end else begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %0b want 1", c - 1, out_valid); end
        n_checks++; if (out_lzc !== lzc[c-1]) begin n_fail++; $display("FAIL b2b_lzc[%0d] got %0d want %0d", c - 1, out_lzc, lzc[c-1]); end
        n_checks++; if (out_norm !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_norm[%0d] got %h want 80000000", c - 1, out_norm); end
        n_checks++; if (out_tag !== t[c-1]) begin n_fail++; $display("FAIL b2b_tag[%0d] got %0d want %0d", c - 1, out_tag, t[c-1]); end
        n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL b2b_zero[%0d] got %0b want 0", c - 1, out_zero); end
      end
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain out_valid got %0b want 0", out_valid); end
  endtask

  // All-zero word followed by an ordinary one.
  task automatic test_zero();
    logic [31:0] d    [2] = '{32'h0000_0000, 32'h0001_2345};
    logic [3:0]  t    [2] = '{4'd5, 4'd6};
    logic [5:0]  lzc  [2] = '{6'b100000, 6'd15};
    logic [31:0] norm [2] = '{32'h0000_0000, 32'h91A2_8000};
    logic        z    [2] = '{1'b1, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      in_valid = (c < 2);
      if (c < 2) begin
        in_data = d[c];
        in_tag  = t[c];
      end
      step();
      if (c >= 1) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid[%0d] got %0b want 1", c - 1, out_valid); end
        n_checks++; if (out_lzc !== lzc[c-1]) begin n_fail++; $display("FAIL zero_lzc[%0d] got %0d want %0d", c - 1, out_lzc, lzc[c-1]); end
        n_checks++; if (out_norm !== norm[c-1]) begin n_fail++; $display("FAIL zero_norm[%0d] got %h want %h", c - 1, out_norm, norm[c-1]); end
        n_checks++; if (out_zero !== z[c-1]) begin n_fail++; $display("FAIL zero_flag[%0d] got %0b want %0b", c - 1, out_zero, z[c-1]); end
        n_checks++; if (out_tag !== t[c-1]) begin n_fail++; $display("FAIL zero_tag[%0d] got %0d want %0d", c - 1, out_tag, t[c-1]); end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  // Stall the output, offer 4 words: only 2 get in; release and all 4 emerge in order.
  task automatic test_backpressure();
    logic [31:0] d    [4] = '{32'h00F0_0000, 32'h0000_00FF, 32'h4000_0001, 32'h0000_0300};
    logic [3:0]  t    [4] = '{4'd6, 4'd7, 4'd8, 4'd9};
    logic [5:0]  lzc  [4] = '{6'd8, 6'd24, 6'd1, 6'd22};
    logic [31:0] norm [4] = '{32'hF000_0000, 32'hFF00_0000, 32'h8000_0002, 32'hC000_0000};
    int  idx  = 0;
    int  oidx = 0;
    logic fi, fo;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_data = d[idx];
        in_tag  = t[idx];
      end
      #1;
      fi = in_valid & in_ready;
      if (c >= 2) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d got %0b want 1", c, out_valid); end
        n_checks++; if (out_norm !== norm[0]) begin n_fail++; $display("FAIL bp_hold_norm c%0d got %h want %h", c, out_norm, norm[0]); end
        n_checks++; if (out_tag !== t[0]) begin n_fail++; $display("FAIL bp_hold_tag c%0d got %0d want %0d", c, out_tag, t[0]); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d got %0b want 0", c, in_ready); end
      end
      step();
      if (fi) idx++;
    end
    n_checks++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_data = d[idx];
        in_tag  = t[idx];
      end
      #1;
      fi = in_valid & in_ready;
      fo = out_valid & out_ready;
      if (fo) begin
        n_checks++;
        if (oidx >= 4) begin
          n_fail++; $display("FAIL bp_extra_output got tag %0d want none", out_tag);
        end else if (out_norm !== norm[oidx] || out_lzc !== lzc[oidx] || out_tag !== t[oidx] || out_zero !== 1'b0) begin
          n_fail++; $display("FAIL bp_out[%0d] got norm %h lzc %0d tag %0d want norm %h lzc %0d tag %0d",
                             oidx, out_norm, out_lzc, out_tag, norm[oidx], lzc[oidx], t[oidx]);
        end
        oidx++;
      end
      step();
      if (fi) idx++;
    end
    n_checks++; if (oidx !== 4) begin n_fail++; $display("FAIL bp_out_count got %0d want 4", oidx); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", out_valid); end
  endtask

  // Random traffic against the reference model, order checked through a queue.
  task automatic test_random();
    localparam int N = 10000;
    res_t        sb[$];
    res_t        exp_r;
    res_t        got;
    logic [31:0] w;
    logic [3:0]  wt;
    logic        have = 1'b0;
    logic        fi, fo;
    int          n_sent = 0;
    int          n_recv = 0;
    int          cyc = 0;
    int          lz;
    while (n_recv < N && cyc < 60000) begin
      if (!have && n_sent < N) begin
        if ($urandom_range(3, 0) == 0) w = 32'd0;
        else begin
          lz = 0;
          while (lz < 31 && $urandom_range(1, 0) == 1) lz++;
          w = (32'($urandom) >> lz) | (32'h8000_0000 >> lz);
        end
        wt = 4'($urandom);
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(1, 0) == 1);
      in_data   = w;
      in_tag    = wt;
      out_ready = ($urandom_range(1, 0) == 1);
      #1;
      fi = in_valid & in_ready;
      fo = out_valid & out_ready;
      if (fo) begin
        n_checks++;
        got = '{norm: out_norm, lzc: out_lzc, zero: out_zero, tag: out_tag};
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected got %h want none", got);
        end else begin
          exp_r = sb.pop_front();
          if (got !== exp_r) begin
            n_fail++; $display("FAIL rand_out[%0d] got %h want %h", n_recv, got, exp_r);
          end
        end
        n_recv++;
      end
      if (fi) begin
        sb.push_back(ref_model(w, wt));
        n_sent++;
        have = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (n_recv != N) begin n_fail++; $display("FAIL rand_timeout received %0d want %0d", n_recv, N); end
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain out_valid got %0b want 0", out_valid); end
  endtask

  // Two words in flight, reset pulsed between edges: valids drop at once, nothing old comes out.
  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    in_tag    = 4'hA;
    step();
    in_data = 32'h0000_0002;
    in_tag  = 4'hB;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %0b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid got %0b want 0", out_valid); end
    n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL rstmid_async_tag got %0d want 0", out_tag); end
    n_checks++; if (out_norm !== 32'd0) begin n_fail++; $display("FAIL rstmid_async_norm got %h want 0", out_norm); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost c%0d got valid tag %0d want none", c, out_tag); end
      step();
    end
  endtask

  // One-hot inputs on the 8/16/64-bit instances.
  task automatic test_sweep();
    for (int k = 0; k < 64; k++) begin
      v8  = (k < 8);
      v16 = (k < 16);
      v64 = 1'b1;
      d8  = (k < 8)  ? 8'(64'd1 << k)  : 8'd0;
      d16 = (k < 16) ? 16'(64'd1 << k) : 16'd0;
      d64 = 64'd1 << k;
      sweep_tag = 4'(k);
      step();
      v8 = 1'b0; v16 = 1'b0; v64 = 1'b0;
      step();
      if (k < 8) begin
        n_checks++; if (ov8 !== 1'b1 || ol8 !== 4'(7 - k) || on8 !== 8'h80 || oz8 !== 1'b0 || ot8 !== 4'(k))
          begin n_fail++; $display("FAIL sweep8 k%0d got v%0b lzc %0d norm %h want v1 lzc %0d norm 80", k, ov8, ol8, on8, 7 - k); end
      end
      if (k < 16) begin
        n_checks++; if (ov16 !== 1'b1 || ol16 !== 5'(15 - k) || on16 !== 16'h8000 || oz16 !== 1'b0 || ot16 !== 4'(k))
          begin n_fail++; $display("FAIL sweep16 k%0d got v%0b lzc %0d norm %h want v1 lzc %0d norm 8000", k, ov16, ol16, on16, 15 - k); end
      end
      n_checks++; if (ov64 !== 1'b1 || ol64 !== 7'(63 - k) || on64 !== 64'h8000_0000_0000_0000 || oz64 !== 1'b0 || ot64 !== 4'(k))
        begin n_fail++; $display("FAIL sweep64 k%0d got v%0b lzc %0d norm %h want v1 lzc %0d norm 8000000000000000", k, ov64, ol64, on64, 63 - k); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
